// File: rtl/eq_seq_ctrl_pkg.sv
// Shared types and default sizing for the equalizer FIR sequencer.
package eq_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    FILL  = 3'd0,
    IDLE  = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  localparam int DEF_NUM_TAPS = 1021;
  localparam int DEF_ADDR_W   = 10;

endpackage

// File: rtl/eq_seq_ctrl_if.sv
// Codec-side sample strobe plus queue/FIR control signals of the sequencer.
interface eq_seq_ctrl_if import eq_seq_ctrl_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);

  logic              smpl_vld;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              sequencing;
  logic              fir_vld;
  logic              busy;
  logic              overrun;

  modport master (
    output smpl_vld,
    input  wr_en, wr_ptr, rd_ptr, sequencing, fir_vld, busy, overrun
  );

  modport slave (
    input  smpl_vld,
    output wr_en, wr_ptr, rd_ptr, sequencing, fir_vld, busy, overrun
  );

endinterface

// File: rtl/circ_ptr.sv
// Loadable modulo-2**ADDR_W pointer; load has priority over increment.
module circ_ptr import eq_seq_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] value
);

  logic [ADDR_W-1:0] value_r;

  // pointer register, wraps silently
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      value_r <= load_val;
    end else if (inc) begin
      value_r <= value_r + ADDR_W'(1);
    end else begin
      value_r <= value_r;
    end
  end

  assign value = value_r;

endmodule

// File: rtl/eq_seq_ctrl.sv
// Sample-queue sequencer: fills the circular queue, then runs one convolution per new sample.
module eq_seq_ctrl import eq_seq_ctrl_pkg::*; #(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  eq_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [CNT_W-1:0]  FILL_LAST = CNT_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0]  TAP_LAST  = CNT_W'(NUM_TAPS);
  localparam logic [ADDR_W-1:0] TAPS_MOD  = ADDR_W'(NUM_TAPS);

  seq_state_t        state_r, state_s;
  logic [CNT_W-1:0]  fill_cnt_r, fill_cnt_s;
  logic [CNT_W-1:0]  tap_cnt_r, tap_cnt_s;
  logic [ADDR_W-1:0] base_r, base_s;
  logic              pending_r, pending_s;
  logic              overrun_r, overrun_s;
  logic              seq_r, fir_vld_r, busy_r;
  logic              rd_load_s, rd_inc_s;
  logic [ADDR_W-1:0] wr_ptr_s, rd_ptr_s;

  circ_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .inc(bus.smpl_vld),
    .load_val({ADDR_W{1'b0}}), .value(wr_ptr_s)
  );

  circ_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk(clk), .rst_n(rst_n), .load(rd_load_s), .inc(rd_inc_s),
    .load_val(base_r), .value(rd_ptr_s)
  );

  // next-state, queue bookkeeping and read-pointer control
  always_comb begin
    state_s    = state_r;
    fill_cnt_s = fill_cnt_r;
    tap_cnt_s  = tap_cnt_r;
    base_s     = base_r;
    pending_s  = pending_r;
    overrun_s  = overrun_r;
    rd_load_s  = 1'b0;
    rd_inc_s   = 1'b0;
    case (state_r)
      FILL: begin
        if (bus.smpl_vld && (fill_cnt_r == FILL_LAST)) begin
          state_s = IDLE;
        end else if (bus.smpl_vld) begin
          fill_cnt_s = fill_cnt_r + CNT_W'(1);
        end else begin
          state_s = FILL;
        end
      end
      IDLE: begin
        // a fresh sample is already in the queue at wr_ptr, hence the +1
        if (bus.smpl_vld) begin
          state_s   = PRIME;
          base_s    = wr_ptr_s + ADDR_W'(1) - TAPS_MOD;
          pending_s = 1'b0;
        end else if (pending_r) begin
          state_s   = PRIME;
          base_s    = wr_ptr_s - TAPS_MOD;
          pending_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      PRIME, RUN: begin
        if (state_r == PRIME) begin
          rd_load_s = 1'b1;
          tap_cnt_s = {CNT_W{1'b0}};
          state_s   = RUN;
        end else if (tap_cnt_r == TAP_LAST) begin
          state_s = DONE;
        end else begin
          rd_inc_s  = 1'b1;
          tap_cnt_s = tap_cnt_r + CNT_W'(1);
        end
        if (bus.smpl_vld) begin
          overrun_s = overrun_r | pending_r;
          pending_s = 1'b1;
        end else begin
          pending_s = pending_r;
        end
      end
      DONE: begin
        // a sample arriving now is queued for the next run even if pending is consumed
        pending_s = bus.smpl_vld;
        if (pending_r) begin
          state_s = PRIME;
          base_s  = wr_ptr_s - TAPS_MOD;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = FILL;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= FILL;
      fill_cnt_r <= {CNT_W{1'b0}};
      tap_cnt_r  <= {CNT_W{1'b0}};
      base_r     <= {ADDR_W{1'b0}};
      pending_r  <= 1'b0;
      overrun_r  <= 1'b0;
      seq_r      <= 1'b0;
      fir_vld_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      fill_cnt_r <= fill_cnt_s;
      tap_cnt_r  <= tap_cnt_s;
      base_r     <= base_s;
      pending_r  <= pending_s;
      overrun_r  <= overrun_s;
      seq_r      <= (state_s == PRIME) || (state_s == RUN);
      fir_vld_r  <= (state_s == DONE);
      busy_r     <= (state_s == PRIME) || (state_s == RUN) || (state_s == DONE);
    end
  end

  assign bus.wr_en      = bus.smpl_vld;
  assign bus.wr_ptr     = wr_ptr_s;
  assign bus.rd_ptr     = rd_ptr_s;
  assign bus.sequencing = seq_r;
  assign bus.fir_vld    = fir_vld_r;
  assign bus.busy       = busy_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// Bench for eq_seq_ctrl: constant vector table, directed run scenarios, random traffic vs timeline model.
module tb_eq_seq_ctrl;
  import eq_seq_ctrl_pkg::*;

  localparam int N     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_seq_ctrl_if #(.ADDR_W(AW)) bus ();

  eq_seq_ctrl #(.NUM_TAPS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fir_q[$];

  // timeline model: a run with PRIME cycle p has sequencing on p..p+N+1, fir_vld at p+N+2
  int m_n = 0;
  bit m_act = 1'b0;
  int m_p = 0;
  int m_base = 0;
  bit m_pend = 1'b0;
  bit m_ovr = 1'b0;
  int m_rd = 0;

  typedef struct {
    logic v;
    logic r;
    int   wp;
    logic seq;
    logic busy;
  } vec_t;
  vec_t tbl[12];

  function automatic int md(input int x);
    return ((x % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void model_step(input bit v, input bit r);
    int c;
    int wr_before;
    int n_before;
    c = cyc;
    if (!r) begin
      m_n = 0; m_act = 1'b0; m_pend = 1'b0; m_ovr = 1'b0; m_rd = 0;
      return;
    end
    n_before  = m_n;
    wr_before = md(m_n);
    if (v) m_n++;
    if (m_act && c == m_p + N + 2) begin
      if (m_pend) begin
        m_p = c + 1; m_base = wr_before - N;
      end else begin
        m_act = 1'b0;
      end
      m_pend = v;
    end else if (m_act) begin
      if (v) begin
        if (m_pend) m_ovr = 1'b1;
        m_pend = 1'b1;
      end
    end else if (n_before < N) begin
      m_pend = 1'b0;
    end else if (v) begin
      m_act = 1'b1; m_p = c + 1; m_base = wr_before + 1 - N; m_pend = 1'b0;
    end else if (m_pend) begin
      m_act = 1'b1; m_p = c + 1; m_base = wr_before - N; m_pend = 1'b0;
    end
  endfunction

  task automatic check_model();
    int k;
    int off;
    k = cyc;
    if (m_act && k >= m_p + 1) begin
      off  = (k - m_p - 1 > N) ? N : k - m_p - 1;
      m_rd = md(m_base + off);
    end
    chk("m_wr_ptr", bus.wr_ptr, md(m_n));
    chk("m_rd_ptr", bus.rd_ptr, m_rd);
    chk("m_seq", bus.sequencing, m_act && k >= m_p && k <= m_p + N + 1);
    chk("m_fir_vld", bus.fir_vld, m_act && k == m_p + N + 2);
    chk("m_busy", bus.busy, m_act && k >= m_p && k <= m_p + N + 2);
    chk("m_overrun", bus.overrun, m_ovr);
    if (bus.fir_vld === 1'b1) fir_q.push_back(cyc);
  endtask

  task automatic cycle(input logic v, input logic r);
    bus.smpl_vld = v;
    rst_n = r;
    #1;
    chk("wr_en", bus.wr_en, v);
    @(posedge clk);
    model_step(v, r);
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  task automatic run_one(input int base, input int wp);
    cycle(1'b1, 1'b1);
    chk("run_wr_ptr", bus.wr_ptr, wp);
    for (int i = 1; i <= 12; i++) begin
      if (i > 1) cycle(1'b0, 1'b1);
      chk("run_seq", bus.sequencing, i <= 10);
      chk("run_fir", bus.fir_vld, i == 11);
      if (i >= 2 && i <= 10) chk("run_rd_ptr", bus.rd_ptr, md(base + i - 2));
    end
  endtask

  initial begin
    int gap;
    tbl[0] = '{1'b0, 1'b0, 0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 0, 1'b0, 1'b0};
    for (int i = 1; i <= 8; i++) tbl[1 + i] = '{1'b1, 1'b1, i, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 8, 1'b0, 1'b0};

    // reset and FILL: eight strobes never start a run
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].v, tbl[i].r);
      chk("tbl_wr_ptr", bus.wr_ptr, tbl[i].wp);
      chk("tbl_seq", bus.sequencing, tbl[i].seq);
      chk("tbl_busy", bus.busy, tbl[i].busy);
    end

    // first run (slot 8, base 1) then runs through the pointer wrap (slot 1, base 10)
    for (int s = 8; s <= 17; s++) run_one(md(s + 1 - N), md(s + 1));

    // back-to-back: one sample during RUN queues a second run
    fir_q.delete();
    cycle(1'b1, 1'b1);
    for (int i = 1; i <= 26; i++) cycle(i == 4, 1'b1);
    chk("b2b_fir_count", fir_q.size(), 2);
    gap = (fir_q.size() >= 2) ? fir_q[1] - fir_q[0] : -1;
    chk("b2b_fir_gap", gap, 11);
    chk("b2b_no_overrun", bus.overrun, 1'b0);

    // overrun: two samples in one RUN, only one extra run
    fir_q.delete();
    cycle(1'b1, 1'b1);
    for (int i = 1; i <= 40; i++) cycle(i == 3 || i == 6, 1'b1);
    chk("ovr_fir_count", fir_q.size(), 2);
    chk("ovr_sticky", bus.overrun, 1'b1);

    // mid-run reset at RUN cycle 4
    cycle(1'b1, 1'b1);
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1);
    chk("pre_rst_seq", bus.sequencing, 1'b1);
    fir_q.delete();
    cycle(1'b0, 1'b0);
    chk("rst_seq", bus.sequencing, 1'b0);
    chk("rst_wr_ptr", bus.wr_ptr, 0);
    chk("rst_overrun", bus.overrun, 1'b0);
    for (int i = 1; i <= 15; i++) cycle(i < 9, 1'b1);
    chk("rst_no_fir", fir_q.size(), 0);
    chk("rst_fill_no_seq", bus.sequencing, 1'b0);

    // random traffic with rare resets
    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 399) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
